// File: rtl/pc_trace_recorder.sv
// PC trace recorder: captures multi-channel samples into a small buffer during a run.
// A run ends when channel 0 repeats HALT_REPEAT times in a row (halt) or when the cycle limit is reached.
module pc_trace_recorder #(
  parameter int DATA_W      = 32,
  parameter int CHANNELS    = 3,
  parameter int DEPTH       = 16,
  parameter int WRAP        = 0,
  parameter int HALT_REPEAT = 4,
  parameter int TIMEOUT     = 1024
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         Start,
  input  logic                         Sample_Valid,
  input  logic [CHANNELS*DATA_W-1:0]   Sample_Data,
  input  logic                         Rd_En,
  output logic [CHANNELS*DATA_W-1:0]   Rd_Data,
  output logic                         Rd_Valid,
  output logic [$clog2(DEPTH):0]       Count,
  output logic                         Overflow,
  output logic [31:0]                  Cycle_Count,
  output logic [1:0]                   State,
  output logic                         Done,
  output logic                         Timeout
);

  localparam int AW = $clog2(DEPTH);
  localparam int SW = CHANNELS * DATA_W;
  localparam int RW = $clog2(HALT_REPEAT + 1);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_HALTED   = 2'd2,
    S_TIMEDOUT = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       cycle_q, cycle_d;
  logic [RW-1:0]     rep_q, rep_d;
  logic [DATA_W-1:0] last_pc_q, last_pc_d;
  logic [SW-1:0]     rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              done_q, done_d;
  logic              timeout_q, timeout_d;

  logic [SW-1:0]     mem [DEPTH];
  logic              mem_we;
  logic              full, do_read, capture, overwrite, halt_hit, restart;

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    cycle_d    = cycle_q;
    rep_d      = rep_q;
    last_pc_d  = last_pc_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;

    full      = (count_q == FULL_COUNT);
    do_read   = Rd_En && (count_q != '0);
    capture   = (state_q == S_RUN) && Sample_Valid;
    restart   = Start && ((state_q == S_HALTED) || (state_q == S_TIMEDOUT));
    // A full buffer accepts a write only if a read frees a slot or overwrite is enabled.
    mem_we    = capture && (!full || do_read || (WRAP != 0));
    overwrite = capture && full && !do_read && (WRAP != 0);

    if (capture && full && !do_read) overflow_d = 1'b1;
    if (mem_we) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_read || overwrite) rd_ptr_d = rd_ptr_q + 1'b1;

    if (do_read) begin
      rd_data_d  = mem[rd_ptr_q];
      rd_valid_d = 1'b1;
    end

    if (mem_we && !do_read && !full) count_d = count_q + 1'b1;
    else if (do_read && !mem_we)     count_d = count_q - 1'b1;

    // Repeat detection sees dropped samples too; rep_q==0 marks the first sample of a run.
    if (capture) begin
      last_pc_d = Sample_Data[DATA_W-1:0];
      if ((rep_q != '0) && (Sample_Data[DATA_W-1:0] == last_pc_q)) rep_d = rep_q + 1'b1;
      else                                                          rep_d = RW'(1);
    end
    halt_hit = capture && (rep_d == RW'(HALT_REPEAT));

    if (state_q == S_RUN) begin
      cycle_d = cycle_q + 32'd1;
      if (halt_hit)                      state_d = S_HALTED;
      else if (cycle_d == 32'(TIMEOUT))  state_d = S_TIMEDOUT;
    end else if ((state_q == S_IDLE) && Start) begin
      state_d = S_RUN;
    end else if (restart) begin
      state_d    = S_RUN;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
      cycle_d    = '0;
      rep_d      = '0;
    end

    done_d    = (state_d == S_HALTED);
    timeout_d = (state_d == S_TIMEDOUT);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      cycle_q    <= '0;
      rep_q      <= '0;
      last_pc_q  <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      cycle_q    <= cycle_d;
      rep_q      <= rep_d;
      last_pc_q  <= last_pc_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
    end
  end

  // NOTE: the storage array has no reset; an entry is only readable after it has been written.
  always_ff @(posedge Clock) begin
    if (mem_we) mem[wr_ptr_q] <= Sample_Data;
  end

  assign Rd_Data     = rd_data_q;
  assign Rd_Valid    = rd_valid_q;
  assign Count       = count_q;
  assign Overflow    = overflow_q;
  assign Cycle_Count = cycle_q;
  assign State       = state_q;
  assign Done        = done_q;
  assign Timeout     = timeout_q;

endmodule

// File: tb/tb_pc_trace_recorder.sv
// Directed bench for pc_trace_recorder: four parameterisations share one stimulus stream,
// each scenario resets everything and checks the instance it targets.
module tb_pc_trace_recorder;

  localparam int SW = 96;

  logic          Clock = 1'b0;
  logic          Reset = 1'b1;
  logic          Start = 1'b0;
  logic          Sample_Valid = 1'b0;
  logic          Rd_En = 1'b0;
  logic [SW-1:0] Sample_Data = '0;

  always #5 Clock = ~Clock;

  // d_: defaults, n_: DEPTH=4 stop-when-full, w_: DEPTH=4 circular, t_: TIMEOUT=8
  logic [SW-1:0] d_rd_data, n_rd_data, w_rd_data, t_rd_data;
  logic          d_rd_valid, n_rd_valid, w_rd_valid, t_rd_valid;
  logic [4:0]    d_count;
  logic [2:0]    n_count, w_count, t_count;
  logic          d_ovf, n_ovf, w_ovf, t_ovf;
  logic [31:0]   d_cycle, n_cycle, w_cycle, t_cycle;
  logic [1:0]    d_state, n_state, w_state, t_state;
  logic          d_done, n_done, w_done, t_done;
  logic          d_tmo, n_tmo, w_tmo, t_tmo;

  pc_trace_recorder u_def (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Sample_Valid(Sample_Valid),
    .Sample_Data(Sample_Data), .Rd_En(Rd_En), .Rd_Data(d_rd_data), .Rd_Valid(d_rd_valid),
    .Count(d_count), .Overflow(d_ovf), .Cycle_Count(d_cycle), .State(d_state),
    .Done(d_done), .Timeout(d_tmo));

  pc_trace_recorder #(.DEPTH(4), .WRAP(0), .TIMEOUT(64)) u_nw (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Sample_Valid(Sample_Valid),
    .Sample_Data(Sample_Data), .Rd_En(Rd_En), .Rd_Data(n_rd_data), .Rd_Valid(n_rd_valid),
    .Count(n_count), .Overflow(n_ovf), .Cycle_Count(n_cycle), .State(n_state),
    .Done(n_done), .Timeout(n_tmo));

  pc_trace_recorder #(.DEPTH(4), .WRAP(1), .TIMEOUT(64)) u_w (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Sample_Valid(Sample_Valid),
    .Sample_Data(Sample_Data), .Rd_En(Rd_En), .Rd_Data(w_rd_data), .Rd_Valid(w_rd_valid),
    .Count(w_count), .Overflow(w_ovf), .Cycle_Count(w_cycle), .State(w_state),
    .Done(w_done), .Timeout(w_tmo));

  pc_trace_recorder #(.DEPTH(4), .TIMEOUT(8)) u_to (
    .Clock(Clock), .Reset(Reset), .Start(Start), .Sample_Valid(Sample_Valid),
    .Sample_Data(Sample_Data), .Rd_En(Rd_En), .Rd_Data(t_rd_data), .Rd_Valid(t_rd_valid),
    .Count(t_count), .Overflow(t_ovf), .Cycle_Count(t_cycle), .State(t_state),
    .Done(t_done), .Timeout(t_tmo));

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Channel 0 = pc, channel 1 = pc+0x100, channel 2 = pc+0x200
  function automatic logic [SW-1:0] smp(input logic [31:0] pc);
    return {pc + 32'h200, pc + 32'h100, pc};
  endfunction

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic reset_all();
    Reset = 1'b1; Start = 1'b0; Sample_Valid = 1'b0; Rd_En = 1'b0; Sample_Data = '0;
    tick();
    Reset = 1'b0;
  endtask

  task automatic start_run();
    Start = 1'b1;
    tick();
    Start = 1'b0;
  endtask

  task automatic push(input logic [31:0] pc);
    Sample_Valid = 1'b1;
    Sample_Data  = smp(pc);
    tick();
    Sample_Valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] halt_pcs [6] = '{32'h0, 32'h4, 32'h8, 32'h8, 32'h8, 32'h8};
  logic [31:0] exp_nw   [4] = '{32'h10, 32'h20, 32'h30, 32'h40};
  logic [31:0] exp_w    [4] = '{32'h30, 32'h40, 32'h50, 32'h60};
  logic [31:0] exp_sim  [4] = '{32'h200, 32'h300, 32'h400, 32'h500};

  initial begin
    // Reset state
    reset_all();
    check("rst_state",    d_state,    2'd0);
    check("rst_count",    d_count,    5'd0);
    check("rst_ovf",      d_ovf,      1'b0);
    check("rst_cycle",    d_cycle,    32'd0);
    check("rst_rd_valid", d_rd_valid, 1'b0);
    check("rst_rd_data",  d_rd_data,  96'd0);
    check("rst_done",     d_done,     1'b0);
    check("rst_timeout",  d_tmo,      1'b0);

    // Halt detection
    start_run();
    check("halt_run_state", d_state, 2'd1);
    for (int i = 0; i < 6; i++) begin
      push(halt_pcs[i]);
      if (i == 4) check("halt_not_yet", d_state, 2'd1);
    end
    check("halt_state", d_state, 2'd2);
    check("halt_done",  d_done,  1'b1);
    check("halt_count", d_count, 5'd6);
    check("halt_cycle", d_cycle, 32'd6);
    push(32'h8);
    push(32'hC);
    check("halt_ignore_count", d_count, 5'd6);
    check("halt_ignore_cycle", d_cycle, 32'd6);
    Rd_En = 1'b1;
    tick();
    Rd_En = 1'b0;
    check("halt_rd_valid", d_rd_valid, 1'b1);
    check("halt_rd_data",  d_rd_data,  smp(32'h0));
    check("halt_rd_count", d_count,    5'd5);
    tick();
    check("halt_rd_pulse", d_rd_valid, 1'b0);

    // Stop-when-full and circular overwrite on identical stimulus
    reset_all();
    start_run();
    for (int i = 1; i <= 6; i++) push(32'(i * 16));
    check("nw_count", n_count, 3'd4);
    check("nw_ovf",   n_ovf,   1'b1);
    check("nw_state", n_state, 2'd1);
    check("w_count",  w_count, 3'd4);
    check("w_ovf",    w_ovf,   1'b1);
    Rd_En = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("nw_rd_valid", n_rd_valid, 1'b1);
      check("nw_rd_data",  n_rd_data,  smp(exp_nw[i]));
      check("w_rd_valid",  w_rd_valid, 1'b1);
      check("w_rd_data",   w_rd_data,  smp(exp_w[i]));
    end
    tick();
    check("nw_empty_rd_valid", n_rd_valid, 1'b0);
    check("nw_empty_rd_hold",  n_rd_data,  smp(32'h40));
    check("w_empty_rd_valid",  w_rd_valid, 1'b0);
    check("w_empty_count",     w_count,    3'd0);
    // Capture plus read while empty: read ignored, write lands
    Sample_Valid = 1'b1;
    Sample_Data  = smp(32'h70);
    tick();
    Sample_Valid = 1'b0;
    Rd_En = 1'b0;
    check("empty_rw_count",    n_count,    3'd1);
    check("empty_rw_rd_valid", n_rd_valid, 1'b0);

    // Simultaneous read and write while full
    reset_all();
    start_run();
    for (int i = 1; i <= 4; i++) push(32'(i * 256));
    check("full_count", n_count, 3'd4);
    Sample_Valid = 1'b1;
    Sample_Data  = smp(32'h500);
    Rd_En        = 1'b1;
    tick();
    Sample_Valid = 1'b0;
    check("full_rw_rd_valid", n_rd_valid, 1'b1);
    check("full_rw_rd_data",  n_rd_data,  smp(32'h100));
    check("full_rw_count",    n_count,    3'd4);
    check("full_rw_ovf",      n_ovf,      1'b0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("full_rw_drain", n_rd_data, smp(exp_sim[i]));
    end
    Rd_En = 1'b0;

    // Reset mid-run discards the buffer regardless of other inputs
    reset_all();
    start_run();
    push(32'h1); push(32'h2); push(32'h3);
    check("mid_count", n_count, 3'd3);
    Reset = 1'b1; Start = 1'b1; Sample_Valid = 1'b1; Rd_En = 1'b1; Sample_Data = smp(32'h9);
    tick();
    Reset = 1'b0; Start = 1'b0; Sample_Valid = 1'b0;
    check("mid_rst_state",    n_state,    2'd0);
    check("mid_rst_count",    n_count,    3'd0);
    check("mid_rst_rd_valid", n_rd_valid, 1'b0);
    check("mid_rst_rd_data",  n_rd_data,  96'd0);
    check("mid_rst_cycle",    n_cycle,    32'd0);
    tick();
    Rd_En = 1'b0;
    check("mid_rst_read", n_rd_valid, 1'b0);

    // Timeout, Start ignored in RUN, restart clears
    reset_all();
    start_run();
    check("to_run_state", t_state, 2'd1);
    check("to_cycle0",    t_cycle, 32'd0);
    push(32'h4);
    push(32'h8);
    check("to_count", t_count, 3'd2);
    start_run();
    check("to_start_ignored", t_cycle, 32'd3);
    repeat (4) tick();
    check("to_pre_state", t_state, 2'd1);
    check("to_pre_cycle", t_cycle, 32'd7);
    check("to_pre_tmo",   t_tmo,   1'b0);
    tick();
    check("to_state", t_state, 2'd3);
    check("to_tmo",   t_tmo,   1'b1);
    check("to_done",  t_done,  1'b0);
    check("to_cycle", t_cycle, 32'd8);
    tick();
    check("to_cycle_hold", t_cycle, 32'd8);
    check("to_count_hold", t_count, 3'd2);
    start_run();
    check("restart_state", t_state, 2'd1);
    check("restart_cycle", t_cycle, 32'd0);
    check("restart_count", t_count, 3'd0);
    check("restart_tmo",   t_tmo,   1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_trace_recorder.md
PC_TRACE_RECORDER -- requirements
Module: pc_trace_recorder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning the width of one channel in bits.
REQ-002 The block SHALL have parameter CHANNELS, default 3, meaning the number of channels per sample; channel 0 is PC, 1 is Inst, 2 is Alu_Result.
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning the number of buffer entries; DEPTH is a power of 2 and ≥2.
REQ-004 The block SHALL have parameter WRAP, default 0, meaning 0 = stop-when-full and 1 = circular overwrite.
REQ-005 The block SHALL have parameter HALT_REPEAT, default 4, meaning the number of identical consecutive channel-0 values that counts as a halt; HALT_REPEAT ≥2.
REQ-006 The block SHALL have parameter TIMEOUT, default 1024, meaning the run-cycle limit.
REQ-007 The block SHALL have port Clock, input, width 1: single clock, rising edge.
REQ-008 The block SHALL have port Reset, input, width 1: synchronous, active-high reset.
REQ-009 The block SHALL have port Start, input, width 1: begin a capture run.
REQ-010 The block SHALL have port Sample_Valid, input, width 1: Sample_Data is valid this cycle.
REQ-011 The block SHALL have port Sample_Data, input, width CHANNELS*DATA_W: channel k occupies bits [k*DATA_W +: DATA_W].
REQ-012 The block SHALL have port Rd_En, input, width 1: pop the oldest entry.
REQ-013 The block SHALL have port Rd_Data, output, width CHANNELS*DATA_W: the popped entry.
REQ-014 The block SHALL have port Rd_Valid, output, width 1: Rd_Data is valid.
REQ-015 The block SHALL have port Count, output, width clog2(DEPTH)+1: current occupancy.
REQ-016 The block SHALL have port Overflow, output, width 1: sticky flag, at least one sample dropped or overwritten.
REQ-017 The block SHALL have port Cycle_Count, output, width 32: cycles spent in RUN.
REQ-018 The block SHALL have port State, output, width 2: 0 = IDLE, 1 = RUN, 2 = HALTED, 3 = TIMEDOUT.
REQ-019 The block SHALL have port Done, output, width 1: State is HALTED.
REQ-020 The block SHALL have port Timeout, output, width 1: State is TIMEDOUT.

Function
REQ-021 The block SHALL move from IDLE to RUN on the clock edge where Start=1.
REQ-022 Start while in RUN SHALL be ignored.
REQ-023 Start while in HALTED or TIMEDOUT SHALL move the block to RUN and, on the same edge, clear the buffer, Count, Overflow, Cycle_Count and the repeat counter.
REQ-024 In RUN, Cycle_Count SHALL increment by 1 every cycle.
REQ-025 On the edge where Cycle_Count reaches TIMEOUT, the block SHALL move to TIMEDOUT; Cycle_Count then holds.
REQ-026 In RUN, a sample with Sample_Valid=1 SHALL be written at the write pointer.
- Count increments.
- No capture occurs outside RUN.
REQ-027 Full with WRAP=0: the sample SHALL be dropped, Count SHALL stay DEPTH, and Overflow SHALL be set.
REQ-028 Full with WRAP=1: the sample SHALL overwrite the oldest entry.
- Read pointer advances.
- Count stays DEPTH.
- Overflow is set.
REQ-029 Capture and Rd_En in the same cycle while full SHALL perform both operations; Count stays DEPTH and Overflow is not set.
REQ-030 Capture and Rd_En in the same cycle while empty SHALL ignore the read; the write proceeds and Count becomes 1.
REQ-031 Rd_En with Count>0 SHALL be honoured in any state.
- Rd_Data and Rd_Valid are registered and appear on the next cycle.
- Rd_Valid pulses for 1 cycle.
REQ-032 Rd_En with Count=0 SHALL leave pointers unchanged; Rd_Valid is 0 and Rd_Data holds its previous value.
REQ-033 Pointers SHALL wrap modulo DEPTH.
REQ-034 The repeat counter SHALL update on each captured or dropped valid sample in RUN.
- Channel-0 equal to the previous valid sample's channel 0: counter increments.
- Otherwise: counter resets to 1.
- First sample after Start: counter is 1.
REQ-035 When a valid sample brings the repeat counter to HALT_REPEAT, that sample SHALL still be captured per REQ-026..028, and the block SHALL move to HALTED on the same edge.
REQ-036 If halt and timeout conditions occur on the same edge, HALTED SHALL take priority.
REQ-037 Done and Timeout SHALL be registered decodes of State.

Reset
REQ-038 Reset=1 at a rising edge SHALL force all of the following, regardless of Start, Sample_Valid or Rd_En:
- State=IDLE
- Count=0, read and write pointers = 0
- Overflow=0, Cycle_Count=0, repeat counter=0
- Rd_Valid=0, Rd_Data=0
- Done=0, Timeout=0
REQ-039 Reset asserted mid-run SHALL discard all buffered samples.
REQ-040 Buffer RAM contents need not be cleared by reset; buffered data is unobservable until rewritten.

Verification
REQ-041 Halt detection: Reset, Start, then 6 valid samples with PC 0,4,8,8,8,8 -> after the 6th edge State=2, Done=1, Count=6; subsequent samples are ignored.
REQ-042 Stop-when-full (WRAP=0, DEPTH=4): Start, then 6 valid samples with PC 0x10..0x60 -> Count=4, Overflow=1, and 4 reads return 0x10, 0x20, 0x30, 0x40.
REQ-043 Circular overwrite (WRAP=1, DEPTH=4): same stimulus as REQ-042 -> Count=4, Overflow=1, and 4 reads return 0x30, 0x40, 0x50, 0x60, after which Rd_En gives Rd_Valid=0.
REQ-044 Timeout (TIMEOUT=8): Start with no halt pattern -> State=3 on the 8th RUN edge with Cycle_Count=8; a second Start returns State=1 with Cycle_Count=0 and Count=0.
REQ-045 Simultaneous read/write when full (DEPTH=4, full): Sample_Valid=1 and Rd_En=1 -> the oldest entry is returned next cycle, Count stays 4 and Overflow stays 0.
REQ-046 Reset mid-run: with Count=3 in RUN, assert Reset for 1 cycle -> State=0, Count=0, and Rd_En gives Rd_Valid=0.
